// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word and instruction-cache address field types
package cpu_types_pkg;
   localparam int IIDX_W = 4;
   localparam int ITAG_W = 32 - 2 - IIDX_W;
   typedef logic [31:0] word_t;
   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: direct-mapped valid/tag/data frames, one write port, one combinational read port
module icache_frame_array import cpu_types_pkg::*; #(
   parameter int IDX_W = IIDX_W,
   parameter int TAG_W = ITAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [TAG_W-1:0] wtag,
   input  word_t            wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic             rvalid,
   output logic [TAG_W-1:0] rtag,
   output word_t            rdata
);
   localparam int N = 1 << IDX_W;
   logic [N-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [N];
   word_t data_q [N];
   // a clear-all in the same cycle as a write wins over the write
   always_comb begin
      valid_d = valid_q;
      if (we) valid_d[widx] = 1'b1;
      if (clr) valid_d = '0;
   end
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else valid_q <= valid_d;
   end
   always_ff @(posedge clk) begin
      if (we && !clr) begin
         tag_q[widx]  <= wtag;
         data_q[widx] <= wdata;
      end
   end
   assign rvalid = valid_q[ridx];
   assign rtag   = tag_q[ridx];
   assign rdata  = data_q[ridx];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: read-only direct-mapped instruction cache with single-word refill and forwarding
module icache_ctrl import cpu_types_pkg::*; #(
   parameter int SETS = 1 << IIDX_W
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        iflush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [0:0] IDLE = 1'b0, FETCH = 1'b1;
   logic [0:0] state_q, state_d;
   logic [29:0] addr_q, addr_d;
   word_t hit_q, hit_d, miss_q, miss_d;
   logic rvalid, hit_i, miss, fill, fwd;
   logic [TAG_W-1:0] rtag;
   word_t rdata;
   icache_frame_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
      .clk(CLK), .rst(nRST), .clr(iflush), .we(fill),
      .widx(addr_q[IDX_W-1:0]), .wtag(addr_q[29:IDX_W]), .wdata(iload),
      .ridx(imemaddr[1+IDX_W:2]), .rvalid(rvalid), .rtag(rtag), .rdata(rdata)
   );
   assign hit_i = !nRST && state_q == IDLE && imemREN && rvalid && rtag == imemaddr[31:2+IDX_W];
   assign miss  = !nRST && state_q == IDLE && imemREN && !hit_i;
   assign fill  = !nRST && state_q == FETCH && !iwait && !iflush;
   // only the address still being requested may take the returning word
   assign fwd   = fill && imemREN && imemaddr[31:2] == addr_q;
   always_comb begin
      state_d = state_q == FETCH ? ((iwait && !iflush) ? FETCH : IDLE) : (miss ? FETCH : IDLE);
      addr_d  = miss ? imemaddr[31:2] : addr_q;
      hit_d   = hit_q + 32'(hit_i);
      miss_d  = miss_q + 32'(miss);
   end
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end
   assign ihit       = hit_i || fwd;
   assign imemload   = fwd ? iload : hit_i ? rdata : '0;
   assign iREN       = !nRST && state_q == FETCH;
   assign iaddr      = iREN ? {addr_q, 2'b00} : '0;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed vector table plus hand sequences for redirect, flush and reset corners
module tb_icache_ctrl;
   logic CLK = 1'b0, nRST, imemREN, iflush, iwait, ihit, iREN;
   logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;
   int total = 0, passed = 0;
   typedef struct {
      logic rst, ren;
      logic [31:0] addr;
      logic flush, iwait;
      logic [31:0] iload;
      logic ihit;
      logic [31:0] load;
      logic iren;
      logic [31:0] iaddr;
   } vec_t;
   localparam logic [31:0] D = 32'h8C010004, E = 32'h11111111, A = 32'hAAAA0001, B = 32'hBBBB0002;
   vec_t tbl [13];
   icache_ctrl #(.SETS(16)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
      .imemload(imemload), .iflush(iflush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
      .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", n, act, exp);
      else passed++;
   endtask
   task automatic step(input vec_t v, input string n);
      @(negedge CLK);
      nRST = v.rst; imemREN = v.ren; imemaddr = v.addr; iflush = v.flush;
      iwait = v.iwait; iload = v.iload;
      #1;
      chk({n, ".ihit"}, {31'd0, ihit}, {31'd0, v.ihit});
      chk({n, ".imemload"}, imemload, v.load);
      chk({n, ".iREN"}, {31'd0, iREN}, {31'd0, v.iren});
      chk({n, ".iaddr"}, iaddr, v.iaddr);
   endtask
   task automatic run(input logic r, input logic ren, input logic [31:0] a, input logic fl,
                      input logic iw, input logic [31:0] il, input logic eh,
                      input logic [31:0] el, input logic er, input logic [31:0] ea, input string n);
      vec_t v;
      v = '{r, ren, a, fl, iw, il, eh, el, er, ea};
      step(v, n);
   endtask
   initial begin
      tbl[0]  = '{1, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 32'h40, 0, 1, 0, 0, 0, 1, 32'h40};
      tbl[3]  = '{0, 1, 32'h40, 0, 1, 0, 0, 0, 1, 32'h40};
      tbl[4]  = '{0, 1, 32'h40, 0, 0, D, 1, D, 1, 32'h40};
      tbl[5]  = '{0, 1, 32'h40, 0, 1, 0, 1, D, 0, 0};
      tbl[6]  = '{0, 1, 32'h42, 0, 1, 0, 1, D, 0, 0};
      tbl[7]  = '{0, 1, 32'h80, 0, 1, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 32'h80, 0, 0, E, 1, E, 1, 32'h80};
      tbl[9]  = '{0, 1, 32'h80, 0, 1, 0, 1, E, 0, 0};
      tbl[10] = '{0, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0};
      tbl[11] = '{0, 1, 32'h40, 0, 0, D, 1, D, 1, 32'h40};
      tbl[12] = '{0, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
         if (i == 0 || i == 1) begin
            chk("reset.hit_count", hit_count, 0);
            chk("reset.miss_count", miss_count, 0);
         end
         if (i == 5) chk("cold.miss_count", miss_count, 1);
      end
      chk("table.hit_count", hit_count, 3);
      chk("table.miss_count", miss_count, 3);
      run(0, 1, 32'h10, 0, 1, 0, 0, 0, 0, 0, "redir.a");
      run(0, 1, 32'h20, 0, 0, A, 0, 0, 1, 32'h10, "redir.b");
      run(0, 1, 32'h20, 0, 1, 0, 0, 0, 0, 0, "redir.c");
      run(0, 1, 32'h20, 0, 0, B, 1, B, 1, 32'h20, "redir.d");
      run(0, 1, 32'h10, 0, 1, 0, 1, A, 0, 0, "redir.e");
      run(0, 0, 32'h40, 1, 1, 0, 0, 0, 0, 0, "flush.f");
      run(0, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0, "flush.g");
      run(0, 1, 32'h40, 1, 1, 0, 0, 0, 1, 32'h40, "flush.h");
      run(0, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0, "flush.i");
      run(0, 1, 32'h40, 0, 0, D, 1, D, 1, 32'h40, "flush.j");
      run(0, 1, 32'h40, 0, 1, 0, 1, D, 0, 0, "flush.k");
      run(0, 1, 32'h80, 0, 1, 0, 0, 0, 0, 0, "rst.l");
      chk("pre_rst.hit_count", hit_count, 5);
      chk("pre_rst.miss_count", miss_count, 7);
      run(0, 1, 32'h80, 0, 1, 0, 0, 0, 1, 32'h80, "rst.m");
      run(1, 1, 32'h80, 0, 0, 32'h123, 0, 0, 0, 0, "rst.n");
      run(0, 0, 32'h80, 0, 1, 0, 0, 0, 0, 0, "rst.o");
      chk("post_rst.hit_count", hit_count, 0);
      chk("post_rst.miss_count", miss_count, 0);
      run(0, 1, 32'h80, 0, 1, 0, 0, 0, 0, 0, "rst.p");
      run(0, 0, 32'h80, 0, 1, 0, 0, 0, 1, 32'h80, "rst.q");
      chk("rst.refetch_miss_count", miss_count, 1);
      chk("rst.refetch_hit_count", hit_count, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
